io_word_bridge: RTL and testbench

- CPU-side front end of the UART byte buffer. It sits between the core's in/out instruction unit and the UART byte buffer (io_read_req/io_write_req/io_ready/io_done/din/dout).
- Packs received bytes into 32-bit words, or returns single bytes zero-extended.
- Queues outgoing bytes in a TX FIFO so CPU writes do not stall on the UART.
- Serialises all traffic to the buffer, which accepts one byte transaction at a time.

---
 rtl/io_pkg.sv | 22 ++
 rtl/io_word_bridge_if.sv | 35 +++
 rtl/io_tx_fifo.sv | 52 +++++
 rtl/io_word_bridge.sv | 132 +++++++++++++
 tb/tb_io_word_bridge.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared FSM encoding and byte-lane mapping for the UART word bridge.
package io_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX_ISSUE = 3'd1,
        S_TX_WAIT  = 3'd2,
        S_RX_ISSUE = 3'd3,
        S_RX_WAIT  = 3'd4,
        S_RX_DONE  = 3'd5
    } state_t;

    // LSB position of byte idx within a 32-bit word; byte mode always uses [7:0].
    function automatic logic [4:0] lane_lsb(input logic [1:0] idx,
                                            input logic       word,
                                            input logic       big_endian);
        if (!word)
            return 5'd0;
        return big_endian ? (5'd24 - {idx, 3'b000}) : {idx, 3'b000};
    endfunction

endpackage

// File: rtl/io_word_bridge_if.sv
// CPU-side and byte-buffer-side signals of the word bridge.
interface io_word_bridge_if;

    logic        cpu_rd_req;
    logic        cpu_rd_word;
    logic        cpu_rd_busy;
    logic        cpu_rd_valid;
    logic [31:0] cpu_rd_data;
    logic        cpu_wr_req;
    logic        cpu_wr_word;
    logic [31:0] cpu_wr_data;
    logic        cpu_wr_ready;
    logic        io_read_req;
    logic        io_write_req;
    logic [7:0]  io_dout;
    logic        io_ready;
    logic        io_done;
    logic [7:0]  io_din;

    // master: the environment (CPU + byte buffer); slave: the bridge itself
    modport master (
        output cpu_rd_req, cpu_rd_word, cpu_wr_req, cpu_wr_word, cpu_wr_data,
               io_ready, io_done, io_din,
        input  cpu_rd_busy, cpu_rd_valid, cpu_rd_data, cpu_wr_ready,
               io_read_req, io_write_req, io_dout
    );

    modport slave (
        input  cpu_rd_req, cpu_rd_word, cpu_wr_req, cpu_wr_word, cpu_wr_data,
               io_ready, io_done, io_din,
        output cpu_rd_busy, cpu_rd_valid, cpu_rd_data, cpu_wr_ready,
               io_read_req, io_write_req, io_dout
    );

endinterface

// File: rtl/io_tx_fifo.sv
// TX byte FIFO: 1- or 4-byte push, 1-byte pop; head is visible combinationally (0-cycle read).
// No internal overflow guard: the caller pushes only while free space allows it.
module io_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            push,
    input  logic            push_word,
    input  logic [3:0][7:0] push_dat,
    input  logic            pop,
    output logic [7:0]      head_dat,
    output logic [CW-1:0]   count,
    output logic [CW-1:0]   free
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] push_n;
    logic          do_pop;

    assign push_n   = !push ? '0 : (push_word ? CW'(4) : CW'(1));
    assign do_pop   = pop && (count != '0);
    assign head_dat = mem[rd_ptr];
    assign free     = CW'(DEPTH) - count;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= push_dat[0];
            for (int k = 1; k < 4; k++)
                if (push_word)
                    mem[wr_ptr + PW'(k)] <= push_dat[k];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + push_n - CW'(do_pop);
        end
    end

endmodule

// File: rtl/io_word_bridge.sv
// Bridges CPU word/byte I/O to a one-byte-at-a-time UART buffer; writes queue in a TX FIFO, reads drain it first.
// cpu_rd_valid follows the final io_done by 2 cycles; cpu_wr_ready drops when fewer than 4 FIFO slots are free.
module io_word_bridge
    import io_pkg::*;
#(
    parameter int TX_DEPTH   = 16,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    io_word_bridge_if.slave bus
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   fifo_free;
    logic [7:0]      fifo_head;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [3:0][7:0] push_dat;
    logic            rd_accept;
    logic            rd_word_q;
    logic [1:0]      byte_cnt;
    logic            last_byte;
    logic [31:0]     acc;

    assign bus.cpu_wr_ready = fifo_free >= CW'(4);
    assign push             = bus.cpu_wr_req && bus.cpu_wr_ready;
    assign rd_accept        = bus.cpu_rd_req && !bus.cpu_rd_busy;
    assign fifo_empty       = fifo_count == '0;
    assign last_byte        = byte_cnt == (rd_word_q ? 2'd3 : 2'd0);

    // push_dat[0] is the first byte onto the wire
    always_comb begin
        push_dat = '0;
        for (int k = 0; k < 4; k++)
            push_dat[k] = bus.cpu_wr_data[lane_lsb(2'(k), bus.cpu_wr_word, BIG_ENDIAN) +: 8];
    end

    io_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_word (bus.cpu_wr_word),
        .push_dat  (push_dat),
        .pop       (pop),
        .head_dat  (fifo_head),
        .count     (fifo_count),
        .free      (fifo_free)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Requests are combinational on io_ready so each lasts exactly the issue cycle.
    always_comb begin
        state_nxt        = state;
        pop              = 1'b0;
        bus.io_write_req = 1'b0;
        bus.io_read_req  = 1'b0;
        bus.io_dout      = '0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty)
                    state_nxt = S_TX_ISSUE;
                else if (bus.cpu_rd_busy)
                    state_nxt = S_RX_ISSUE;
            end
            S_TX_ISSUE: begin
                if (bus.io_ready) begin
                    bus.io_write_req = 1'b1;
                    bus.io_dout      = fifo_head;
                    pop              = 1'b1;
                    state_nxt        = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                if (bus.io_done)
                    state_nxt = S_IDLE;
            end
            S_RX_ISSUE: begin
                if (bus.io_ready) begin
                    bus.io_read_req = 1'b1;
                    state_nxt       = S_RX_WAIT;
                end
            end
            S_RX_WAIT: begin
                if (bus.io_done)
                    state_nxt = last_byte ? S_RX_DONE : S_RX_ISSUE;
            end
            S_RX_DONE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_word_q        <= 1'b0;
            byte_cnt         <= 2'd0;
            acc              <= '0;
            bus.cpu_rd_busy  <= 1'b0;
            bus.cpu_rd_valid <= 1'b0;
            bus.cpu_rd_data  <= '0;
        end else begin
            bus.cpu_rd_valid <= 1'b0;
            if (rd_accept) begin
                bus.cpu_rd_busy <= 1'b1;
                rd_word_q       <= bus.cpu_rd_word;
                acc             <= '0;
            end
            if (state == S_RX_WAIT && bus.io_done) begin
                acc[lane_lsb(byte_cnt, rd_word_q, BIG_ENDIAN) +: 8] <= bus.io_din;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == S_RX_DONE) begin
                bus.cpu_rd_data  <= acc;
                bus.cpu_rd_valid <= 1'b1;
                bus.cpu_rd_busy  <= 1'b0;
                byte_cnt         <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_io_word_bridge.sv
// Scoreboard bench for io_word_bridge with a behavioural UART byte-buffer model.
module tb_io_word_bridge;

    localparam int DEPTH = 16;
    localparam bit BE    = 1'b1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    io_word_bridge_if bus();

    io_word_bridge #(.TX_DEPTH(DEPTH), .BIG_ENDIAN(BE)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_rd[$];
    logic [7:0]  rx_q[$];
    int          pushed = 0;
    int          issued = 0;
    int          wr_done = 0;
    int          rd_bytes_done = 0;
    int          rd_snap = 0;
    bit          rd_pend = 1'b0;
    bit          ready_en = 1'b1;
    bit          model_busy = 1'b0;

    assign bus.io_ready = ready_en && !model_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Byte buffer: accepts one request while ready, completes 1..3 cycles later.
    initial begin : buf_model
        bit is_rd;
        bus.io_done = 1'b0;
        bus.io_din  = 8'h00;
        forever begin
            @(negedge CLK);
            if (!RST && bus.io_ready && (bus.io_write_req || bus.io_read_req)) begin
                is_rd = bus.io_read_req;
                @(posedge CLK);
                #1 model_busy = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
                bus.io_done = 1'b1;
                if (is_rd) begin
                    bus.io_din = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                    rd_bytes_done++;
                end else begin
                    bus.io_din = 8'($urandom);
                    wr_done++;
                end
                @(posedge CLK);
                #1;
                bus.io_done = 1'b0;
                model_busy  = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic [7:0]  eb;
        logic [31:0] ew;
        forever begin
            @(negedge CLK);
            if (bus.io_write_req || bus.io_read_req) begin
                check("req_exclusive", {31'b0, bus.io_write_req & bus.io_read_req}, 32'd0);
                check("req_while_ready", {31'b0, bus.io_ready}, 32'd1);
            end
            if (bus.io_write_req) begin
                if (exp_tx.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL tx_unexpected: actual byte=%h required=none", bus.io_dout);
                end else begin
                    eb = exp_tx.pop_front();
                    check("tx_byte", {24'b0, bus.io_dout}, {24'b0, eb});
                end
                issued++;
            end
            if (bus.io_read_req)
                check("writes_before_read", {31'b0, wr_done >= rd_snap}, 32'd1);
            if (bus.cpu_rd_valid) begin
                if (exp_rd.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL rd_unexpected: actual data=%h required=no valid", bus.cpu_rd_data);
                end else begin
                    ew = exp_rd.pop_front();
                    check("rd_data", bus.cpu_rd_data, ew);
                end
                rd_pend = 1'b0;
            end
        end
    end

    // One CPU cycle: optional write and/or read, expectations recorded in the scoreboard.
    task automatic op(input bit wr_en, input bit wr_word, input logic [31:0] wr_data,
                      input bit rd_en, input bit rd_word, input logic [31:0] rd_bytes);
        bit rdy_m;
        @(posedge CLK);
        #1;
        bus.cpu_wr_req  = wr_en;
        bus.cpu_wr_word = wr_word;
        bus.cpu_wr_data = wr_data;
        bus.cpu_rd_req  = rd_en;
        bus.cpu_rd_word = rd_word;
        if (wr_en) begin
            rdy_m = (DEPTH - (pushed - issued)) >= 4;
            check("wr_ready", {31'b0, bus.cpu_wr_ready}, {31'b0, rdy_m});
            if (rdy_m) begin
                if (!wr_word) begin
                    exp_tx.push_back(wr_data[7:0]);
                    pushed++;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        exp_tx.push_back(BE ? wr_data[31 - 8*k -: 8] : wr_data[8*k +: 8]);
                        pushed++;
                    end
                end
            end
        end
        if (rd_en && !rd_pend) begin
            check("rd_not_busy", {31'b0, bus.cpu_rd_busy}, 32'd0);
            rd_pend = 1'b1;
            rd_snap = pushed;
            for (int k = 0; k < (rd_word ? 4 : 1); k++)
                rx_q.push_back(rd_bytes[8*k +: 8]);
            if (!rd_word)
                exp_rd.push_back({24'b0, rd_bytes[7:0]});
            else if (BE)
                exp_rd.push_back({rd_bytes[7:0], rd_bytes[15:8], rd_bytes[23:16], rd_bytes[31:24]});
            else
                exp_rd.push_back(rd_bytes);
        end
        @(posedge CLK);
        #1;
        bus.cpu_wr_req = 1'b0;
        bus.cpu_rd_req = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((wr_done != pushed || rd_pend || model_busy) && cyc < 3000) begin
            @(posedge CLK);
            cyc++;
        end
        if (cyc >= 3000) begin
            n_total++;
            n_bad++;
            $display("FAIL idle_timeout: actual wr_left=%0d rd_pend=%0d required=0", pushed - wr_done, rd_pend);
        end
        repeat (2) @(posedge CLK);
    endtask

    task automatic check_quiet_outputs(input string name);
        check(name, {bus.cpu_rd_busy, bus.cpu_rd_valid, bus.io_read_req, bus.io_write_req,
                     bus.io_dout, 20'b0}, 32'd0);
        check({name, "_data"}, bus.cpu_rd_data, 32'd0);
        check({name, "_wr_ready"}, {31'b0, bus.cpu_wr_ready}, 32'd1);
    endtask

    initial begin : stimulus
        int base_iss;
        int base_rd;
        int cyc;
        bit we, ww, re, rw;
        bus.cpu_rd_req  = 1'b0;
        bus.cpu_rd_word = 1'b0;
        bus.cpu_wr_req  = 1'b0;
        bus.cpu_wr_word = 1'b0;
        bus.cpu_wr_data = '0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_quiet_outputs("reset_state");
        @(posedge CLK);
        #1 RST = 1'b0;

        op(1'b1, 1'b0, 32'h0000_0041, 1'b0, 1'b0, 32'h0);
        wait_idle();
        op(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        wait_idle();
        op(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h7856_3412);
        wait_idle();
        op(1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_005A);
        wait_idle();

        // second read lands while the first is busy and must be dropped
        op(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0033);
        op(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h9988_7766);
        wait_idle();

        ready_en = 1'b0;
        base_iss = issued;
        for (int i = 0; i < 16; i++)
            op(1'b1, 1'b0, 32'(8'hA0 + i), 1'b0, 1'b0, 32'h0);
        ready_en = 1'b1;
        wait_idle();
        check("bp_drained", 32'(issued - base_iss), 32'd13);

        base_rd = rd_bytes_done;
        op(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4433_2211);
        cyc = 0;
        while (rd_bytes_done < base_rd + 2 && cyc < 500) begin
            @(posedge CLK);
            #2;
            cyc++;
        end
        check("mid_read_bytes", 32'(rd_bytes_done - base_rd), 32'd2);
        @(posedge CLK);
        #1;
        RST      = 1'b1;
        ready_en = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_quiet_outputs("mid_reset");
        rx_q.delete();
        exp_rd.delete();
        rd_pend = 1'b0;
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        ready_en = 1'b1;
        op(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hD4C3_B2A1);
        wait_idle();

        for (int i = 0; i < 80; i++) begin
            we = ($urandom_range(0, 2) != 0);
            ww = $urandom_range(0, 1) == 1;
            re = ($urandom_range(0, 3) == 0) && !rd_pend;
            rw = $urandom_range(0, 1) == 1;
            op(we, ww, $urandom, re, rw, $urandom);
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 8)) @(posedge CLK);
        end
        wait_idle();

        check("tx_queue_empty", exp_tx.size(), 32'd0);
        check("rd_queue_empty", exp_rd.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
